// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler and its baud divider.
package uart_pkg;

  localparam int UART_FRAME_BITS = 10;
  localparam int BYTE_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshake plus the tx_block drive signals owned by the scheduler.
interface uart_tx_sched_if #(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]                   REQ_VALID;
  logic [uart_pkg::BYTE_W*N_REQ-1:0]  REQ_DATA;
  logic [N_REQ-1:0]                   REQ_READY;
  logic                               STROBE;
  logic [uart_pkg::BYTE_W-1:0]        DATA;
  logic                               NEW_DATA;
  logic                               BUSY;
  logic [2:0]                         GRANT_ID;

  // master is the requester/observer side, slave is the scheduler itself
  modport master (
    output REQ_VALID, REQ_DATA,
    input  REQ_READY, STROBE, DATA, NEW_DATA, BUSY, GRANT_ID
  );

  modport slave (
    input  REQ_VALID, REQ_DATA,
    output REQ_READY, STROBE, DATA, NEW_DATA, BUSY, GRANT_ID
  );

endinterface

// File: rtl/baud_gen.sv
// Free-running baud divider; STROBE is a registered one-cycle pulse every CLK_DIV clocks.
module baud_gen #(
  parameter int CLK_DIV = 868
) (
  input  logic CLK,
  input  logic RST_N,
  output logic STROBE
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      STROBE  <= 1'b0;
    end else begin
      STROBE  <= (div_cnt == DIV_MAX);
      div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one tx_block among N_REQ byte requesters,
// sequencing load, frame bit count and optional inter-frame gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int CLK_DIV    = 868,
  parameter int FRAME_BITS = UART_FRAME_BITS,
  parameter int GAP_BITS   = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  uart_tx_sched_if.slave   bus
);

  localparam int BW = $clog2(FRAME_BITS + 1);

  tx_state_t          state, state_next;
  logic               strobe;
  logic [BW-1:0]      bit_cnt, bit_cnt_d;
  logic [3:0]         gap_cnt, gap_cnt_d;
  logic [2:0]         last, last_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic [2:0]         gid_q, gid_d;
  logic               nd_q, nd_d;

  logic               found_hi, found_lo, any_valid;
  logic [2:0]         hi_idx, lo_idx, grant_idx;
  logic [BYTE_W-1:0]  grant_byte;
  logic [N_REQ-1:0]   grant_onehot;
  logic               frame_done, gap_done;

  baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .STROBE (strobe)
  );

  assign frame_done = strobe && (bit_cnt == BW'(FRAME_BITS - 1));
  assign gap_done   = strobe && (gap_cnt == 4'(GAP_BITS - 1));

  // Lowest valid index above `last` wins; otherwise wrap to the lowest valid index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (((bus.REQ_VALID >> i) & N_REQ'(1)) != '0) begin
        if (i > int'(last)) begin
          found_hi = 1'b1;
          hi_idx   = 3'(i);
        end else begin
          found_lo = 1'b1;
          lo_idx   = 3'(i);
        end
      end
    end
    any_valid    = found_hi | found_lo;
    grant_idx    = found_hi ? hi_idx : lo_idx;
    grant_byte   = BYTE_W'(bus.REQ_DATA >> (BYTE_W * int'(grant_idx)));
    grant_onehot = N_REQ'(1) << grant_idx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      last    <= 3'(N_REQ - 1);
      ready_q <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      nd_q    <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      last    <= last_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      nd_q    <= nd_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_valid)  state_next = ST_LOAD;
      ST_LOAD: if (strobe)     state_next = ST_SEND;
      ST_SEND: if (frame_done) state_next = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_done)   state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // The load strobe counts as bit 1 of the frame; gap counter is re-armed on every send strobe.
  always_comb begin
    ready_d   = '0;
    data_d    = data_q;
    gid_d     = gid_q;
    last_d    = last;
    nd_d      = nd_q;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (any_valid) begin
          ready_d = grant_onehot;
          data_d  = grant_byte;
          gid_d   = grant_idx;
          last_d  = grant_idx;
          nd_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (strobe) begin
          nd_d      = 1'b0;
          bit_cnt_d = BW'(1);
        end
      end
      ST_SEND: begin
        if (strobe) begin
          bit_cnt_d = bit_cnt + 1'b1;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (strobe) gap_cnt_d = gap_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.REQ_READY = ready_q;
  assign bus.STROBE    = strobe;
  assign bus.DATA      = data_q;
  assign bus.NEW_DATA  = nd_q;
  assign bus.BUSY      = (state != ST_IDLE);
  assign bus.GRANT_ID  = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched using three configurations
// (single requester, two requesters, single requester with a 2-bit gap).
module tb_uart_tx_sched;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  int   sel    = 0;
  logic sel_busy, sel_strobe, sel_nd, sel_ready;

  always #5 CLK = ~CLK;

  uart_tx_sched_if #(.N_REQ(1)) ifa ();
  uart_tx_sched_if #(.N_REQ(2)) ifb ();
  uart_tx_sched_if #(.N_REQ(1)) ifc ();

  uart_tx_sched #(.N_REQ(1), .CLK_DIV(4), .FRAME_BITS(10), .GAP_BITS(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(ifa.slave));
  uart_tx_sched #(.N_REQ(2), .CLK_DIV(4), .FRAME_BITS(10), .GAP_BITS(0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(ifb.slave));
  uart_tx_sched #(.N_REQ(1), .CLK_DIV(4), .FRAME_BITS(10), .GAP_BITS(2)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .bus(ifc.slave));

  always_comb begin
    sel_busy = 1'b0; sel_strobe = 1'b0; sel_nd = 1'b0; sel_ready = 1'b0;
    case (sel)
      0: begin sel_busy = ifa.BUSY; sel_strobe = ifa.STROBE; sel_nd = ifa.NEW_DATA; sel_ready = |ifa.REQ_READY; end
      1: begin sel_busy = ifb.BUSY; sel_strobe = ifb.STROBE; sel_nd = ifb.NEW_DATA; sel_ready = |ifb.REQ_READY; end
      2: begin sel_busy = ifc.BUSY; sel_strobe = ifc.STROBE; sel_nd = ifc.NEW_DATA; sel_ready = |ifc.REQ_READY; end
      default: ;
    endcase
  end

  task automatic do_reset();
    RST_N = 1'b0;
    ifa.REQ_VALID = '0; ifa.REQ_DATA = '0;
    ifb.REQ_VALID = '0; ifb.REQ_DATA = '0;
    ifc.REQ_VALID = '0; ifc.REQ_DATA = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Walks one frame from its grant cycle until BUSY drops, sampling at negedges.
  task automatic measure(output int busy_c, output int strb, output int nd_c,
                         output int nd_bad, output int rdy_c, output bit timeout);
    busy_c = 0; strb = 0; nd_c = 0; nd_bad = 0; rdy_c = 0; timeout = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!sel_busy) begin timeout = 1'b0; break; end
      busy_c++;
      if (sel_nd) nd_c++;
      if (sel_ready) rdy_c++;
      if (sel_nd !== (strb == 0)) nd_bad++;
      if (sel_strobe) strb++;
      @(negedge CLK);
    end
  endtask

  task automatic wait_ready(output int idle_c, output bit timeout);
    idle_c = 0; timeout = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (sel_ready) begin timeout = 1'b0; break; end
      if (!sel_busy) idle_c++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (ifb.STROBE !== 1'b0)    begin fails++; $display("[TB] FAIL reset_strobe: got %b expected 0", ifb.STROBE); end
    checks++; if (ifb.DATA !== 8'h00)     begin fails++; $display("[TB] FAIL reset_data: got %h expected 00", ifb.DATA); end
    checks++; if (ifb.NEW_DATA !== 1'b0)  begin fails++; $display("[TB] FAIL reset_new_data: got %b expected 0", ifb.NEW_DATA); end
    checks++; if (ifb.REQ_READY !== 2'b00) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 00", ifb.REQ_READY); end
    checks++; if (ifb.BUSY !== 1'b0)      begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", ifb.BUSY); end
    checks++; if (ifb.GRANT_ID !== 3'd0)  begin fails++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", ifb.GRANT_ID); end
  endtask

  task automatic test_single();
    int b, s, n, nb, r;
    bit to;
    sel = 0;
    do_reset();
    @(negedge CLK);
    ifa.REQ_VALID = 1'b1; ifa.REQ_DATA = 8'h53;
    @(negedge CLK);
    checks++; if (ifa.REQ_READY !== 1'b1) begin fails++; $display("[TB] FAIL single_ready: got %b expected 1", ifa.REQ_READY); end
    checks++; if (ifa.NEW_DATA !== 1'b1)  begin fails++; $display("[TB] FAIL single_new_data: got %b expected 1", ifa.NEW_DATA); end
    checks++; if (ifa.BUSY !== 1'b1)      begin fails++; $display("[TB] FAIL single_busy: got %b expected 1", ifa.BUSY); end
    checks++; if (ifa.DATA !== 8'h53)     begin fails++; $display("[TB] FAIL single_data: got %h expected 53", ifa.DATA); end
    ifa.REQ_VALID = 1'b0;
    measure(b, s, n, nb, r, to);
    checks++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL single_timeout: got %b expected 0", to); end
    checks++; if (s != 10)  begin fails++; $display("[TB] FAIL single_strobes: got %0d expected 10", s); end
    checks++; if (b != 39)  begin fails++; $display("[TB] FAIL single_busy_cycles: got %0d expected 39", b); end
    checks++; if (n != 3)   begin fails++; $display("[TB] FAIL single_nd_cycles: got %0d expected 3", n); end
    checks++; if (nb != 0)  begin fails++; $display("[TB] FAIL single_nd_shape: got %0d bad cycles expected 0", nb); end
    checks++; if (r != 1)   begin fails++; $display("[TB] FAIL single_ready_width: got %0d expected 1", r); end
    checks++; if (ifa.DATA !== 8'h53) begin fails++; $display("[TB] FAIL single_data_hold: got %h expected 53", ifa.DATA); end
  endtask

  task automatic test_strobe_grant();
    int b, s, n, nb, r;
    bit to, seen;
    sel = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (ifa.STROBE) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL sgrant_strobe_seen: got %b expected 1", seen); end
    ifa.REQ_VALID = 1'b1; ifa.REQ_DATA = 8'hC7;
    @(negedge CLK);
    checks++; if (ifa.REQ_READY !== 1'b1) begin fails++; $display("[TB] FAIL sgrant_ready: got %b expected 1", ifa.REQ_READY); end
    checks++; if (ifa.DATA !== 8'hC7)     begin fails++; $display("[TB] FAIL sgrant_data: got %h expected c7", ifa.DATA); end
    ifa.REQ_VALID = 1'b0;
    measure(b, s, n, nb, r, to);
    checks++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL sgrant_timeout: got %b expected 0", to); end
    checks++; if (n != 4)   begin fails++; $display("[TB] FAIL sgrant_nd_cycles: got %0d expected 4", n); end
    checks++; if (s != 10)  begin fails++; $display("[TB] FAIL sgrant_strobes: got %0d expected 10", s); end
    checks++; if (b != 40)  begin fails++; $display("[TB] FAIL sgrant_busy_cycles: got %0d expected 40", b); end
    checks++; if (nb != 0)  begin fails++; $display("[TB] FAIL sgrant_nd_shape: got %0d bad cycles expected 0", nb); end
  endtask

  task automatic test_round_robin();
    int idle, exp_id;
    bit to;
    logic [7:0] exp_data;
    sel = 1;
    do_reset();
    ifb.REQ_DATA = {8'hB2, 8'hA1}; ifb.REQ_VALID = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_ready(idle, to);
      exp_id   = f % 2;
      exp_data = (exp_id == 1) ? 8'hB2 : 8'hA1;
      checks++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL rr_timeout[%0d]: got %b expected 0", f, to); end
      checks++; if (ifb.REQ_READY !== 2'(1 << exp_id)) begin fails++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", f, ifb.REQ_READY, 2'(1 << exp_id)); end
      checks++; if (ifb.GRANT_ID !== 3'(exp_id)) begin fails++; $display("[TB] FAIL rr_grant_id[%0d]: got %0d expected %0d", f, ifb.GRANT_ID, exp_id); end
      checks++; if (ifb.DATA !== exp_data) begin fails++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", f, ifb.DATA, exp_data); end
      if (f > 0) begin
        checks++; if (idle != 1) begin fails++; $display("[TB] FAIL rr_back_to_back[%0d]: got %0d idle cycles expected 1", f, idle); end
      end
    end
    ifb.REQ_VALID = 2'b00;
  endtask

  task automatic test_gap();
    int b, s, n, nb, r;
    bit to;
    sel = 2;
    do_reset();
    ifc.REQ_DATA = 8'h6E; ifc.REQ_VALID = 1'b1;
    @(negedge CLK);
    checks++; if (ifc.REQ_READY !== 1'b1) begin fails++; $display("[TB] FAIL gap_ready1: got %b expected 1", ifc.REQ_READY); end
    measure(b, s, n, nb, r, to);
    checks++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL gap_timeout1: got %b expected 0", to); end
    checks++; if (s != 12)  begin fails++; $display("[TB] FAIL gap_strobes1: got %0d expected 12", s); end
    checks++; if (b != 48)  begin fails++; $display("[TB] FAIL gap_busy_cycles1: got %0d expected 48", b); end
    @(negedge CLK);
    checks++; if (ifc.REQ_READY !== 1'b1) begin fails++; $display("[TB] FAIL gap_ready2: got %b expected 1", ifc.REQ_READY); end
    measure(b, s, n, nb, r, to);
    checks++; if (to !== 1'b0) begin fails++; $display("[TB] FAIL gap_timeout2: got %b expected 0", to); end
    checks++; if (s != 12)  begin fails++; $display("[TB] FAIL gap_strobes2: got %0d expected 12", s); end
    checks++; if (b != 47)  begin fails++; $display("[TB] FAIL gap_busy_cycles2: got %0d expected 47", b); end
    checks++; if (n != 3)   begin fails++; $display("[TB] FAIL gap_nd_cycles2: got %0d expected 3", n); end
    ifc.REQ_VALID = 1'b0;
  endtask

  task automatic test_reset_mid();
    int idle;
    bit to;
    sel = 1;
    do_reset();
    ifb.REQ_DATA = {8'hB2, 8'hA1}; ifb.REQ_VALID = 2'b11;
    repeat (11) @(negedge CLK);
    checks++; if (ifb.BUSY !== 1'b1)     begin fails++; $display("[TB] FAIL rmid_busy_before: got %b expected 1", ifb.BUSY); end
    checks++; if (ifb.NEW_DATA !== 1'b0) begin fails++; $display("[TB] FAIL rmid_nd_before: got %b expected 0", ifb.NEW_DATA); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (ifb.BUSY !== 1'b0)       begin fails++; $display("[TB] FAIL rmid_busy: got %b expected 0", ifb.BUSY); end
    checks++; if (ifb.DATA !== 8'h00)      begin fails++; $display("[TB] FAIL rmid_data: got %h expected 00", ifb.DATA); end
    checks++; if (ifb.REQ_READY !== 2'b00) begin fails++; $display("[TB] FAIL rmid_ready: got %b expected 00", ifb.REQ_READY); end
    checks++; if (ifb.STROBE !== 1'b0)     begin fails++; $display("[TB] FAIL rmid_strobe: got %b expected 0", ifb.STROBE); end
    @(negedge CLK);
    RST_N = 1'b1;
    wait_ready(idle, to);
    checks++; if (to !== 1'b0)             begin fails++; $display("[TB] FAIL rmid_timeout: got %b expected 0", to); end
    checks++; if (ifb.REQ_READY !== 2'b01) begin fails++; $display("[TB] FAIL rmid_regrant: got %b expected 01", ifb.REQ_READY); end
    checks++; if (ifb.DATA !== 8'hA1)      begin fails++; $display("[TB] FAIL rmid_regrant_data: got %h expected a1", ifb.DATA); end
    ifb.REQ_VALID = 2'b00;
  endtask

  task automatic test_withdraw();
    int idle, early;
    bit to;
    sel = 1;
    do_reset();
    ifb.REQ_DATA = {8'h5A, 8'hA1}; ifb.REQ_VALID = 2'b01;
    @(negedge CLK);
    checks++; if (ifb.REQ_READY !== 2'b01) begin fails++; $display("[TB] FAIL wd_first: got %b expected 01", ifb.REQ_READY); end
    ifb.REQ_VALID = 2'b00;
    repeat (6) @(negedge CLK);
    ifb.REQ_DATA = {8'h5A, 8'h3C}; ifb.REQ_VALID = 2'b11;
    early = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (sel_ready) early++;
    end
    checks++; if (early != 0) begin fails++; $display("[TB] FAIL wd_grant_in_send: got %0d grants expected 0", early); end
    ifb.REQ_VALID = 2'b01;
    wait_ready(idle, to);
    checks++; if (to !== 1'b0)             begin fails++; $display("[TB] FAIL wd_timeout: got %b expected 0", to); end
    checks++; if (ifb.REQ_READY !== 2'b01) begin fails++; $display("[TB] FAIL wd_ready: got %b expected 01", ifb.REQ_READY); end
    checks++; if (ifb.GRANT_ID !== 3'd0)   begin fails++; $display("[TB] FAIL wd_grant_id: got %0d expected 0", ifb.GRANT_ID); end
    checks++; if (ifb.DATA !== 8'h3C)      begin fails++; $display("[TB] FAIL wd_data: got %h expected 3c", ifb.DATA); end
    ifb.REQ_VALID = 2'b00;
  endtask

  initial begin
    ifa.REQ_VALID = '0; ifa.REQ_DATA = '0;
    ifb.REQ_VALID = '0; ifb.REQ_DATA = '0;
    ifc.REQ_VALID = '0; ifc.REQ_DATA = '0;
    #2;
    $display("[TB] starting uart_tx_sched bench");
    test_reset();
    test_single();
    test_strobe_grant();
    test_round_robin();
    test_gap();
    test_reset_mid();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
